// File: rtl/const_mult_pipe.sv
// Pipelined unsigned multiply-by-constant: y = round(x*K / 2^FRAC), saturated to OUT_W bits.
// Three register stages share one enable. Data moves on a valid/ready handshake.
module const_mult_pipe #(
  parameter int IN_W  = 21,
  parameter int K     = 43,
  parameter int K_W   = 6,
  parameter int FRAC  = 0,
  parameter int OUT_W = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] y,
  output logic             sat,
  output logic             ovf_flag,
  input  logic             clr_ovf
);

  localparam int PW = IN_W + K_W;
  localparam int RW = PW + 1;
  // The compare width always leaves at least one bit above OUT_W to detect overflow.
  localparam int CW = (RW > OUT_W) ? RW : OUT_W + 1;
  localparam logic [K_W-1:0] K_BITS = K_W'(K);

  if (K < 1 || K >= (1 << K_W) || FRAC < 0 || FRAC > IN_W + K_W - 1) begin : g_param_check
    $error("const_mult_pipe: illegal K/K_W/FRAC combination");
  end

  logic             en;
  logic [IN_W-1:0]  x1_q, x1_d;
  logic             v1_q, v1_d;
  logic [PW-1:0]    p_q, p_d;
  logic             v2_q, v2_d;
  logic [OUT_W-1:0] y_q, y_d;
  logic             sat_q, sat_d;
  logic             out_valid_q, out_valid_d;
  logic             sat_new_q, sat_new_d;
  logic             ovf_flag_q, ovf_flag_d;

  logic [PW-1:0]    prod;
  logic [RW-1:0]    r;
  logic [CW-1:0]    r_wide;
  logic             r_sat;
  logic [OUT_W-1:0] r_y;

  // One shifted copy of x per set bit of K.
  always_comb begin
    prod = '0;
    for (int i = 0; i < K_W; i++) begin
      if (K_BITS[i]) prod = prod + (PW'(x1_q) << i);
    end
  end

  if (FRAC > 0) begin : g_round
    localparam logic [RW-1:0] HALF = RW'(1) << (FRAC - 1);
    assign r = ({1'b0, p_q} + HALF) >> FRAC;
  end else begin : g_no_round
    assign r = {1'b0, p_q};
  end

  assign r_wide = CW'(r);
  assign r_sat  = |r_wide[CW-1:OUT_W];
  assign r_y    = r_sat ? {OUT_W{1'b1}} : r_wide[OUT_W-1:0];

  // NOTE: every *_d gets a hold default first so no path through this block infers a latch.
  always_comb begin
    en          = ~out_valid_q | out_ready;
    x1_d        = x1_q;
    v1_d        = v1_q;
    p_d         = p_q;
    v2_d        = v2_q;
    y_d         = y_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    if (en) begin
      x1_d        = x;
      v1_d        = in_valid;
      p_d         = prod;
      v2_d        = v1_q;
      y_d         = r_y;
      sat_d       = r_sat;
      out_valid_d = v2_q;
    end
    // Single-cycle marker for a fresh saturated result, so a stalled output sets the flag once.
    sat_new_d  = en & v2_q & r_sat;
    ovf_flag_d = (ovf_flag_q & ~clr_ovf) | sat_new_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      y_q         <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      sat_new_q   <= 1'b0;
      ovf_flag_q  <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      y_q         <= y_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      sat_new_q   <= sat_new_d;
      ovf_flag_q  <= ovf_flag_d;
    end
  end

  // NOTE: stage data registers carry no reset; their valid bits alone say whether they hold anything.
  always_ff @(posedge clk) begin
    x1_q <= x1_d;
    p_q  <= p_d;
  end

  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign sat       = sat_q;
  assign ovf_flag  = ovf_flag_q;

endmodule

// File: tb/tb_const_mult_pipe.sv
// Directed bench for const_mult_pipe: three instances cover the default, saturating and
// rounding configurations; expected values are hand-computed constants.
module tb_const_mult_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Default configuration: IN_W=21, K=43, K_W=6, FRAC=0, OUT_W=30
  logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_sat, d_ovf, d_clr;
  logic [20:0] d_x;
  logic [29:0] d_y;
  // Saturating configuration: IN_W=8, K=200, K_W=8, FRAC=0, OUT_W=8
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_sat, s_ovf, s_clr;
  logic [7:0]  s_x, s_y;
  // Rounding configuration: IN_W=8, K=3, K_W=2, FRAC=2, OUT_W=8
  logic        r_in_valid, r_in_ready, r_out_valid, r_out_ready, r_sat, r_ovf, r_clr;
  logic [7:0]  r_x, r_y;

  const_mult_pipe u_def (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready), .x(d_x),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .y(d_y), .sat(d_sat),
    .ovf_flag(d_ovf), .clr_ovf(d_clr)
  );

  const_mult_pipe #(.IN_W(8), .K(200), .K_W(8), .FRAC(0), .OUT_W(8)) u_sat (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .x(s_x),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .y(s_y), .sat(s_sat),
    .ovf_flag(s_ovf), .clr_ovf(s_clr)
  );

  const_mult_pipe #(.IN_W(8), .K(3), .K_W(2), .FRAC(2), .OUT_W(8)) u_rnd (
    .clk(clk), .rst(rst), .in_valid(r_in_valid), .in_ready(r_in_ready), .x(r_x),
    .out_valid(r_out_valid), .out_ready(r_out_ready), .y(r_y), .sat(r_sat),
    .ovf_flag(r_ovf), .clr_ovf(r_clr)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [20:0] t1_x [3] = '{21'd1, 21'd2, 21'h1FFFFF};
  logic [29:0] t1_y [3] = '{30'd43, 30'd86, 30'd90177493};
  logic [7:0]  t3_x [4] = '{8'd1, 8'd2, 8'd5, 8'd255};
  logic [7:0]  t3_y [4] = '{8'd1, 8'd2, 8'd4, 8'd191};
  logic [20:0] t4_x [4] = '{21'd10, 21'd11, 21'd12, 21'd13};
  logic [29:0] t4_y [4] = '{30'd430, 30'd473, 30'd516, 30'd559};
  logic [29:0] got_q [$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    logic fin, fout;

    rst = 1'b1;
    d_in_valid = 0; d_out_ready = 1; d_clr = 0; d_x = '0;
    s_in_valid = 0; s_out_ready = 1; s_clr = 0; s_x = '0;
    r_in_valid = 0; r_out_ready = 1; r_clr = 0; r_x = '0;
    step();
    step();
    check("rst_out_valid", d_out_valid, 0);
    check("rst_y", d_y, 0);
    check("rst_sat", d_sat, 0);
    check("rst_ovf", d_ovf, 0);
    check("rst_sat_ovf", s_ovf, 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", d_in_ready, 1);

    // Back-to-back stream, latency 3, including the largest input.
    for (int c = 0; c < 6; c++) begin
      d_in_valid = (c < 3);
      if (c < 3) d_x = t1_x[c];
      step();
      if (c >= 2 && c < 5) begin
        check("t1_valid", d_out_valid, 1);
        check("t1_y", d_y, t1_y[c-2]);
        check("t1_sat", d_sat, 0);
      end else begin
        check("t1_valid_idle", d_out_valid, 0);
      end
    end

    // Saturation, sticky flag one cycle later, then clear.
    s_in_valid = 1; s_x = 8'd2;
    step();
    s_in_valid = 0;
    step();
    step();
    check("t2_valid", s_out_valid, 1);
    check("t2_y", s_y, 255);
    check("t2_sat", s_sat, 1);
    check("t2_ovf_not_yet", s_ovf, 0);
    step();
    check("t2_ovf_set", s_ovf, 1);
    check("t2_valid_after", s_out_valid, 0);
    s_clr = 1;
    step();
    s_clr = 0;
    check("t2_ovf_clr", s_ovf, 0);

    // 200 fits in 8 bits: no saturation, flag stays low.
    s_in_valid = 1; s_x = 8'd1;
    step();
    s_in_valid = 0;
    step();
    step();
    check("t2b_y", s_y, 200);
    check("t2b_sat", s_sat, 0);
    step();
    check("t2b_ovf", s_ovf, 0);

    // Set and clear in the same cycle: set wins.
    s_in_valid = 1; s_x = 8'd3;
    step();
    s_in_valid = 0;
    step();
    step();
    check("t6_sat", s_sat, 1);
    s_clr = 1;
    step();
    s_clr = 0;
    check("t6_ovf_set_wins", s_ovf, 1);
    s_clr = 1;
    step();
    s_clr = 0;
    check("t6_ovf_cleared", s_ovf, 0);

    // Round-half-up with FRAC=2.
    for (int c = 0; c < 7; c++) begin
      r_in_valid = (c < 4);
      if (c < 4) r_x = t3_x[c];
      step();
      if (c >= 2 && c < 6) begin
        check("t3_valid", r_out_valid, 1);
        check("t3_y", r_y, t3_y[c-2]);
        check("t3_sat", r_sat, 0);
      end else begin
        check("t3_valid_idle", r_out_valid, 0);
      end
    end

    // Stall with out_ready low while the first result is presented.
    k = 0;
    for (int c = 0; c < 20; c++) begin
      d_out_ready = !(c >= 3 && c <= 7);
      d_in_valid  = (k < 4);
      if (k < 4) d_x = t4_x[k];
      #1;
      if (c >= 3 && c <= 7) begin
        check("t4_in_ready_stall", d_in_ready, 0);
        check("t4_valid_stall", d_out_valid, 1);
        check("t4_y_hold", d_y, 430);
      end
      fin  = d_in_valid & d_in_ready;
      fout = d_out_valid & d_out_ready;
      if (fout) got_q.push_back(d_y);
      step();
      if (fin) k++;
    end
    d_in_valid = 0; d_out_ready = 1;
    check("t4_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) check("t4_order", got_q[i], t4_y[i]);
      else check("t4_missing", 0, t4_y[i]);
    end

    // Reset with three items in flight discards them all.
    for (int c = 0; c < 3; c++) begin
      d_in_valid = 1; d_x = 21'(100 + c);
      step();
    end
    check("t5_pre_valid", d_out_valid, 1);
    check("t5_pre_y", d_y, 4300);
    d_in_valid = 0; d_out_ready = 0; rst = 1;
    step();
    rst = 0; d_out_ready = 1;
    check("t5_rst_valid", d_out_valid, 0);
    check("t5_rst_y", d_y, 0);
    for (int c = 0; c < 4; c++) begin
      step();
      check("t5_no_ghost", d_out_valid, 0);
    end
    d_in_valid = 1; d_x = 21'd7;
    step();
    d_in_valid = 0;
    check("t5_lat1", d_out_valid, 0);
    step();
    check("t5_lat2", d_out_valid, 0);
    step();
    check("t5_lat3_valid", d_out_valid, 1);
    check("t5_lat3_y", d_y, 301);
    step();
    check("t5_drained", d_out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
